quot_rem_rebuild_47: RTL

//  Inverse of the constant divide-by-47 datapath: rebuilds the 24-bit dividend
//  as x = q*47 + r from a quotient/remainder pair.

---
 rtl/quot_rem_rebuild_47_if.sv | 27 ++
 rtl/quot_rem_rebuild_47.sv | 91 +++++++++
 2 files changed

// File: rtl/quot_rem_rebuild_47_if.sv
// Handshake bundle for the quotient/remainder rebuild block: pair input side and result output side.
// Both sides use valid/ready: a transfer happens at a rising edge where valid and ready are both high.
interface quot_rem_rebuild_47_if #(
  parameter int XW = 24,
  parameter int QW = 19,
  parameter int RW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q_in;
  logic [RW-1:0] r_in;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] x_out;
  logic          ovf;
  logic          rem_err;

  modport master (
    output in_valid, q_in, r_in, out_ready,
    input  in_ready, out_valid, x_out, ovf, rem_err
  );

  modport slave (
    input  in_valid, q_in, r_in, out_ready,
    output in_ready, out_valid, x_out, ovf, rem_err
  );
endinterface

// File: rtl/quot_rem_rebuild_47.sv
// Rebuilds x = q*47 + r with a 4-bit-per-cycle shift-add, LSB quotient digit first.
// Flags remainders >= 47 and results that do not fit in 24 bits.
module quot_rem_rebuild_47 (
  input  logic                   clk,
  input  logic                   rst,
  quot_rem_rebuild_47_if.slave   bus,
  output logic [1:0]             state_dbg
);
  localparam int XW      = 24;
  localparam int QW      = 19;
  localparam int RW      = 6;
  localparam int DIVISOR = 47;
  localparam int DIGIT   = 4;
  localparam int NDIG    = (QW + DIGIT - 1) / DIGIT;
  localparam int QPW     = NDIG * DIGIT;
  localparam int AW      = QW + RW + 1;
  localparam int KW      = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [QPW-1:0]  qreg;
  logic [AW-1:0]   acc;
  logic [KW-1:0]   k;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   acc_next;
  logic [XW-1:0]   x_q;
  logic            ovf_q;
  logic            rem_err_q;
  logic            out_valid_q;

  // Current digit's contribution, placed at its digit position.
  always_comb begin
    addend   = '0;
    addend   = (AW'(qreg[DIGIT-1:0]) * AW'(DIVISOR)) << (k * DIGIT);
    acc_next = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      qreg        <= '0;
      acc         <= '0;
      k           <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      rem_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            qreg      <= QPW'(bus.q_in);
            acc       <= AW'(bus.r_in);
            rem_err_q <= (bus.r_in >= RW'(DIVISOR));
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          qreg <= qreg >> DIGIT;
          k    <= k + 1'b1;
          if (k == KW'(NDIG - 1)) begin
            x_q         <= acc_next[XW-1:0];
            ovf_q       <= |acc_next[AW-1:XW];
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;
  assign bus.ovf       = ovf_q;
  assign bus.rem_err   = rem_err_q;
  assign state_dbg     = state;
endmodule
